// File: rtl/n_to_1_demux_stream.sv
// Demultiplexes one valid/ready stream onto N independently buffered output ports.
// Optional DEMUX_DROP_CNT_EN adds a saturating drop_cnt output counting out-of-range beats.
module n_to_1_demux_stream #(
  parameter int N  = 6,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic [SW-1:0]  in_sel,
  output logic [N-1:0]   out_valid,
  input  logic [N-1:0]   out_ready,
  output logic [N*W-1:0] out_data,
`ifdef DEMUX_DROP_CNT_EN
  output logic [15:0]    drop_cnt,
`endif
  output logic           err_sel
);

  logic         sel_oob;
  logic [N-1:0] port_sel;
  logic [N-1:0] lane_ready;
  logic         accept;
  logic         err_sel_reg;

  // A power-of-two N leaves no unused select codes, so nothing can ever be dropped.
  generate
    if (N == (1 << SW)) begin : g_pow2
      assign sel_oob = 1'b0;
    end else begin : g_npow2
      assign sel_oob = (in_sel >= SW'(N));
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_port
      logic         valid_reg, valid_next;
      logic [W-1:0] data_reg, data_next;
      logic         push;

      assign port_sel[gi]   = (in_sel == SW'(gi));
      assign lane_ready[gi] = !valid_reg || out_ready[gi];

      // A push in the same cycle as a pop refills the slot, so there is no bubble.
      always_comb begin
        push       = accept && port_sel[gi];
        valid_next = valid_reg && !out_ready[gi];
        data_next  = data_reg;
        if (push) begin
          valid_next = 1'b1;
          data_next  = in_data;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          valid_reg <= valid_next;
          data_reg  <= data_next;
        end
      end

      assign out_valid[gi]        = valid_reg;
      assign out_data[gi*W +: W]  = data_reg;
    end
  endgenerate

  assign in_ready = sel_oob || |(port_sel & lane_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sel_reg <= 1'b0;
    end else begin
      err_sel_reg <= in_valid && sel_oob;
    end
  end

  assign err_sel = err_sel_reg;

`ifdef DEMUX_DROP_CNT_EN
  logic [15:0] drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_reg <= '0;
    end else if (in_valid && sel_oob && (drop_cnt_reg != 16'hFFFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_n_to_1_demux_stream.sv
// Randomised and directed checks of n_to_1_demux_stream against a per-port slot model.
// Build with DEMUX_DROP_CNT_EN defined to also cover the drop counter.
module tb_n_to_1_demux_stream;
  localparam int N  = 6;
  localparam int W  = 8;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic [SW-1:0]  in_sel = '0;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready = '0;
  logic [N*W-1:0] out_data;
  logic           err_sel;
`ifdef DEMUX_DROP_CNT_EN
  logic [15:0]    drop_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one slot per port plus the error flag and drop count.
  logic         m_valid [N];
  logic [W-1:0] m_data  [N];
  logic         m_err;
  int           m_cnt;

  n_to_1_demux_stream #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef DEMUX_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .err_sel   (err_sel)
  );

  always #5 clk = ~clk;

  function automatic logic exp_ready();
    if (int'(in_sel) >= N) return 1'b1;
    return !m_valid[in_sel] || out_ready[in_sel];
  endfunction

  function automatic logic [N-1:0] exp_valid();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = m_valid[k];
    return v;
  endfunction

  function automatic logic [N*W-1:0] exp_data();
    logic [N*W-1:0] d = '0;
    for (int k = 0; k < N; k++) if (m_valid[k]) d[k*W +: W] = m_data[k];
    return d;
  endfunction

  // DUT payload with empty lanes blanked, since their contents are unspecified.
  function automatic logic [N*W-1:0] seen_data();
    logic [N*W-1:0] d = '0;
    for (int k = 0; k < N; k++) if (out_valid[k]) d[k*W +: W] = out_data[k*W +: W];
    return d;
  endfunction

  task automatic drive(input logic v, input int sel, input logic [W-1:0] d, input logic [N-1:0] rdy);
    in_valid  = v;
    in_sel    = SW'(sel);
    in_data   = d;
    out_ready = rdy;
    #1;
  endtask

  task automatic tick();
    logic acc;
    @(posedge clk);
    acc = in_valid && exp_ready();
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        m_valid[k] = 1'b0;
        m_data[k]  = '0;
      end
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (acc && int'(in_sel) == k) begin
          m_valid[k] = 1'b1;
          m_data[k]  = in_data;
        end else if (m_valid[k] && out_ready[k]) begin
          m_valid[k] = 1'b0;
        end
      end
      m_err = in_valid && (int'(in_sel) >= N);
      if (m_err && m_cnt < 65535) m_cnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom_range(0, 7), W'($urandom), N'($urandom));
      vectors++;
      if (in_ready !== exp_ready()) begin
        miscompares++;
        $display("FAIL reset_in_ready: got %b want %b", in_ready, exp_ready());
      end
      tick();
      vectors++;
      if (out_valid !== '0 || out_data !== '0 || err_sel !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state: valid=%b data=%h err=%b want all zero", out_valid, out_data, err_sel);
      end
`ifdef DEMUX_DROP_CNT_EN
      vectors++;
      if (drop_cnt !== 16'd0) begin
        miscompares++;
        $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt);
      end
`endif
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_fill();
    logic [W-1:0] d2 = W'($urandom);
    drive(1'b1, 2, 8'hA5, '0);
    tick();
    vectors++;
    if (out_valid !== 6'b000100 || out_data[2*W +: W] !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_fill: valid=%b data=%h want 000100/a5", out_valid, out_data[2*W +: W]);
    end
    drive(1'b1, 2, d2, '0);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_fill_blocked: in_ready=%b want 0", in_ready);
    end
    tick();
    vectors++;
    if (out_data[2*W +: W] !== 8'hA5 || out_valid !== 6'b000100) begin
      miscompares++;
      $display("FAIL single_fill_hold: valid=%b data=%h want 000100/a5", out_valid, out_data[2*W +: W]);
    end
    drive(1'b0, 0, '0, '1);
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 0, '0, '1);
    tick();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 3, W'(i), 6'b001000);
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_in_ready beat %0d: got %b want 1", i, in_ready);
      end
      tick();
      vectors++;
      if (out_valid[3] !== 1'b1 || out_data[3*W +: W] !== W'(i)) begin
        miscompares++;
        $display("FAIL b2b_out beat %0d: valid=%b data=%h want 1/%h", i, out_valid[3], out_data[3*W +: W], W'(i));
      end
    end
    drive(1'b0, 0, '0, 6'b001000);
    tick();
    vectors++;
    if (out_valid !== 6'b000000) begin
      miscompares++;
      $display("FAIL b2b_drain: valid=%b want 000000", out_valid);
    end
  endtask

  task automatic test_bad_sel();
    logic [N-1:0] ov;
    drive(1'b1, 4, W'($urandom), '0);
    tick();
    ov = out_valid;
    for (int s = 6; s <= 7; s++) begin
      drive(1'b1, s, W'($urandom), '0);
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL bad_sel_ready sel=%0d: got %b want 1", s, in_ready);
      end
      tick();
      vectors++;
      if (err_sel !== 1'b1 || out_valid !== ov || out_valid !== exp_valid()) begin
        miscompares++;
        $display("FAIL bad_sel sel=%0d: err=%b valid=%b want 1/%b", s, err_sel, out_valid, ov);
      end
    end
    drive(1'b0, 7, W'($urandom), '0);
    tick();
    vectors++;
    if (err_sel !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_sel_pulse: err=%b want 0", err_sel);
    end
`ifdef DEMUX_DROP_CNT_EN
    vectors++;
    if (int'(drop_cnt) !== m_cnt) begin
      miscompares++;
      $display("FAIL bad_sel_drop_cnt: got %0d want %0d", drop_cnt, m_cnt);
    end
`endif
    drive(1'b0, 0, '0, '1);
    tick();
  endtask

  task automatic test_independent_drain();
    logic [W-1:0] d0 = W'($urandom);
    logic [W-1:0] d5 = W'($urandom);
    drive(1'b1, 0, d0, '0);
    tick();
    drive(1'b1, 5, d5, '0);
    tick();
    vectors++;
    if (out_valid !== 6'b100001 || out_data[5*W +: W] !== d5) begin
      miscompares++;
      $display("FAIL drain_fill: valid=%b d5=%h want 100001/%h", out_valid, out_data[5*W +: W], d5);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 0, '0, 6'b100000);
      tick();
      vectors++;
      if (out_valid !== 6'b000001 || out_data[W-1:0] !== d0) begin
        miscompares++;
        $display("FAIL drain_port0 cycle %0d: valid=%b d0=%h want 000001/%h", i, out_valid, out_data[W-1:0], d0);
      end
    end
    drive(1'b0, 0, '0, '1);
    tick();
  endtask

  task automatic test_reset_midstream();
    logic [W-1:0] d = W'($urandom);
    drive(1'b1, 1, W'($urandom), '0);
    tick();
    drive(1'b1, 4, W'($urandom), '0);
    tick();
    rst_n = 1'b0;
    drive(1'b0, 0, '0, '0);
    tick();
    rst_n = 1'b1;
    vectors++;
    if (out_valid !== 6'b000000) begin
      miscompares++;
      $display("FAIL midreset_valid: got %b want 000000", out_valid);
    end
`ifdef DEMUX_DROP_CNT_EN
    vectors++;
    if (drop_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL midreset_drop_cnt: got %0d want 0", drop_cnt);
    end
`endif
    drive(1'b1, 1, d, '0);
    tick();
    vectors++;
    if (out_valid !== 6'b000010 || out_data[W +: W] !== d) begin
      miscompares++;
      $display("FAIL midreset_resume: valid=%b d=%h want 000010/%h", out_valid, out_data[W +: W], d);
    end
    drive(1'b0, 0, '0, '1);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drive(1'($urandom), $urandom_range(0, 7), W'($urandom), N'($urandom));
      vectors++;
      if (in_ready !== exp_ready()) begin
        miscompares++;
        $display("FAIL rand_in_ready cyc %0d: got %b want %b", i, in_ready, exp_ready());
      end
      tick();
      vectors++;
      if (out_valid !== exp_valid() || seen_data() !== exp_data() || err_sel !== m_err) begin
        miscompares++;
        $display("FAIL rand_out cyc %0d: valid=%b data=%h err=%b want %b/%h/%b",
                 i, out_valid, seen_data(), err_sel, exp_valid(), exp_data(), m_err);
      end
`ifdef DEMUX_DROP_CNT_EN
      vectors++;
      if (int'(drop_cnt) !== m_cnt) begin
        miscompares++;
        $display("FAIL rand_drop_cnt cyc %0d: got %0d want %0d", i, drop_cnt, m_cnt);
      end
`endif
    end
    rst_n = 1'b1;
  endtask

`ifdef DEMUX_DROP_CNT_EN
  task automatic test_drop_saturate();
    drive(1'b1, 7, W'($urandom), '0);
    repeat (65537) tick();
    vectors++;
    if (drop_cnt !== 16'hFFFF || m_cnt != 65535) begin
      miscompares++;
      $display("FAIL drop_saturate: got %h want ffff", drop_cnt);
    end
    drive(1'b0, 0, '0, '1);
    tick();
  endtask
`endif

  initial begin
    for (int k = 0; k < N; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = '0;
    end
    m_err = 1'b0;
    m_cnt = 0;
    test_reset();
    test_single_fill();
    test_back_to_back();
    test_bad_sel();
    test_independent_drain();
    test_reset_midstream();
    test_random();
`ifdef DEMUX_DROP_CNT_EN
    test_drop_saturate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
